// File: rtl/vga_timing_pkg.sv
// Timing constants and shared types for the 800x600 @ 72 Hz scanner.
// Horizontal and vertical limits are inclusive counter values.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 12;
  localparam int unsigned COLOR_W = 12;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COLOR_W-1:0] color_t;

  // Horizontal: visible 0..799, porch 800..855, sync 856..975, porch 976..1039.
  localparam coord_t H_VISIBLE    = 12'd800;
  localparam coord_t H_SYNC_START = 12'd856;
  localparam coord_t H_SYNC_END   = 12'd975;
  localparam coord_t H_TOTAL      = 12'd1040;
  localparam coord_t H_LAST       = H_TOTAL - 12'd1;

  // Vertical: visible 0..599, porch 600..636, sync 637..642, porch 643..665.
  localparam coord_t V_VISIBLE    = 12'd600;
  localparam coord_t V_SYNC_START = 12'd637;
  localparam coord_t V_SYNC_END   = 12'd642;
  localparam coord_t V_TOTAL      = 12'd666;
  localparam coord_t V_LAST       = V_TOTAL - 12'd1;

  function automatic logic in_range(coord_t c, coord_t lo, coord_t hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/scan_counter.sv
// Horizontal/vertical raster counters with wrap and the pre-frame reset preload.
// Exposes current and next-state positions so outputs can be registered in step.
module scan_counter
  import vga_timing_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   advance,
  output coord_t h,
  output coord_t v,
  output coord_t h_next,
  output coord_t v_next,
  output logic   visible,
  output logic   visible_next
);

  always_comb begin
    h_next = (h == H_LAST) ? '0 : h + 12'd1;
    v_next = v;
    if (h == H_LAST) begin
      v_next = (v == V_LAST) ? '0 : v + 12'd1;
    end
  end

  assign visible      = (h < H_VISIBLE) && (v < V_VISIBLE);
  assign visible_next = (h_next < H_VISIBLE) && (v_next < V_VISIBLE);

  // Preload the last position so the first advance lands on (0,0).
  always_ff @(posedge clk) begin
    if (reset) begin
      h <= H_LAST;
      v <= V_LAST;
    end else if (advance) begin
      h <= h_next;
      v <= v_next;
    end
  end

endmodule

// File: rtl/vga_scanner.sv
// VGA 800x600 @ 72 Hz scanner: queries pixel responders one pixel ahead and
// registers colour and syncs on every second clk.
module vga_scanner
  import vga_timing_pkg::*;
#(
  parameter color_t FG_COLOR = 12'hFFF,
  parameter color_t BG_COLOR = 12'h000
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   isFilled,
  output coord_t x_p,
  output coord_t y_p,
  output color_t rgb,
  output logic   hsync,
  output logic   vsync,
  output logic   pix_en,
  output logic   frame_start
);

  logic   phase;
  coord_t h, v, h_next, v_next;
  logic   visible, visible_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= 1'b0;
    end else begin
      phase <= ~phase;
    end
  end

  assign pix_en = phase;

  scan_counter u_scan (
    .clk          (clk),
    .reset        (reset),
    .advance      (phase),
    .h            (h),
    .v            (v),
    .h_next       (h_next),
    .v_next       (v_next),
    .visible      (visible),
    .visible_next (visible_next)
  );

  // Blanking parks the query on the last visible column so the responder's
  // "next pixel" lands on the first pixel of the upcoming visible line.
  assign x_p = visible ? h : (H_VISIBLE - 12'd1);
  assign y_p = (v < V_VISIBLE) ? v : (V_VISIBLE - 12'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb         <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (phase) begin
        rgb         <= visible_next ? (isFilled ? FG_COLOR : BG_COLOR) : '0;
        hsync       <= in_range(h_next, H_SYNC_START, H_SYNC_END);
        vsync       <= in_range(v_next, V_SYNC_START, V_SYNC_END);
        frame_start <= (h_next == '0) && (v_next == '0);
      end
    end
  end

endmodule
